// File: rtl/apb_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and constants for the APB3 master arbiter. It provides:
//   - state_e       : FSM state encoding (IDLE, SETUP, ACCESS)
//   - SLOT_W/PSEL_W : 4-bit slot index decoded onto a 16-bit PSEL vector
//   - APB_AW/APB_DW : APB address / data widths
//   - psel_decode() : slot index to one-hot PSEL
// -----------------------------------------------------------------------------
package apb_arb_pkg;

   localparam int SLOT_W = 4;
   localparam int PSEL_W = 16;
   localparam int APB_AW = 32;
   localparam int APB_DW = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   function automatic logic [PSEL_W-1:0] psel_decode(input logic [SLOT_W-1:0] slot);
      logic [PSEL_W-1:0] sel;
      sel = '0;
      sel[slot] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/apb_arb_rr.sv
// -----------------------------------------------------------------------------
// apb_arb_rr
// Combinational round-robin picker. It grants the first requester at or after
// the rotating pointer.
// Ports:
//   req_i [NREQ]  request vector
//   ptr_i [PTR_W] highest-priority requester index (always < NREQ)
//   gnt_o [NREQ]  one-hot grant
//   idx_o [PTR_W] binary index of the grant
//   vld_o         a grant was issued
// -----------------------------------------------------------------------------
module apb_arb_rr #(
   parameter int NREQ  = 4,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             vld_o
);

   int               j;
   logic [PTR_W-1:0] j_idx;

   // Scan from the furthest position back towards ptr_i, so the candidate
   // nearest the pointer is written last and wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      j     = 0;
      j_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         if (j >= NREQ) j = j - NREQ;
         j_idx = PTR_W'(j);
         if (req_i[j_idx]) begin
            gnt_o        = '0;
            gnt_o[j_idx] = 1'b1;
            idx_o        = j_idx;
            vld_o        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB3 master port between NREQ local requesters. Arbitration is
// round-robin. The block runs the SETUP and ACCESS phases and decodes a 16-slot
// PSEL from PADDR[SLOT_LSB+3:SLOT_LSB]. It honours PREADY wait states and
// returns PRDATA/PSLVERR to the granted requester with a one-cycle DONE pulse.
// All outputs are registered.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to abandon an ACCESS phase after
// TIMEOUT cycles without PREADY. An abandoned transfer completes with RSP_ERR=1
// and RSP_RDATA=0.
//
// Ports:
//   PCLK, PRESETN                  clock, asynchronous active-low reset
//   REQ/REQ_WRITE [NREQ]           per-requester request level / direction
//   REQ_ADDR/REQ_WDATA [NREQ*32]   packed address / write data, slot i at [32i+:32]
//   DONE [NREQ]                    one-hot completion pulse
//   RSP_RDATA, RSP_ERR             response, valid while DONE != 0
//   BUSY                           high outside IDLE
//   PADDR, PSEL, PENABLE, PWRITE, PWDATA, PRDATA, PREADY, PSLVERR  APB3 master
// -----------------------------------------------------------------------------
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int SLOT_LSB = 24,
   parameter int TIMEOUT  = 255
) (
   input  logic                 PCLK,
   input  logic                 PRESETN,
   input  logic [NREQ-1:0]      REQ,
   input  logic [NREQ-1:0]      REQ_WRITE,
   input  logic [NREQ*32-1:0]   REQ_ADDR,
   input  logic [NREQ*32-1:0]   REQ_WDATA,
   output logic [NREQ-1:0]      DONE,
   output logic [APB_DW-1:0]    RSP_RDATA,
   output logic                 RSP_ERR,
   output logic                 BUSY,
   output logic [APB_AW-1:0]    PADDR,
   output logic [PSEL_W-1:0]    PSEL,
   output logic                 PENABLE,
   output logic                 PWRITE,
   output logic [APB_DW-1:0]    PWDATA,
   input  logic [APB_DW-1:0]    PRDATA,
   input  logic                 PREADY,
   input  logic                 PSLVERR
);

   localparam int PTR_W = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("apb_master_arbiter: NREQ must be 2..8");
   end
   if (SLOT_LSB < 0 || SLOT_LSB > APB_AW - SLOT_W) begin : g_bad_slot
      $error("apb_master_arbiter: SLOT_LSB out of range");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("apb_master_arbiter: TIMEOUT must be >= 1");
   end

   state_e              state_q;
   logic [PTR_W-1:0]    ptr_q;
   logic [PTR_W-1:0]    gidx_q;
   logic [NREQ-1:0]     gnt_q;
   logic [NREQ-1:0]     done_q;
   logic [APB_DW-1:0]   rdata_q;
   logic                err_q;
   logic                busy_q;
   logic [APB_AW-1:0]   paddr_q;
   logic [PSEL_W-1:0]   psel_q;
   logic                penable_q;
   logic                pwrite_q;
   logic [APB_DW-1:0]   pwdata_q;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]    cnt_q;
`endif

   logic [NREQ-1:0]     gnt;
   logic [PTR_W-1:0]    gnt_idx;
   logic                gnt_vld;
   logic [APB_AW-1:0]   addr_d;
   logic [APB_DW-1:0]   wdata_d;
   logic [PTR_W-1:0]    ptr_d;

   apb_arb_rr #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req_i (REQ),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .vld_o (gnt_vld)
   );

   assign addr_d  = REQ_ADDR[32*gnt_idx +: APB_AW];
   assign wdata_d = REQ_WDATA[32*gnt_idx +: APB_DW];
   // The requester just served moves to lowest priority.
   assign ptr_d   = (gidx_q == PTR_W'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gidx_q    <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         paddr_q   <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (gnt_vld) begin
                  state_q  <= SETUP;
                  busy_q   <= 1'b1;
                  gnt_q    <= gnt;
                  gidx_q   <= gnt_idx;
                  paddr_q  <= addr_d;
                  pwrite_q <= REQ_WRITE[gnt_idx];
                  pwdata_q <= wdata_d;
                  psel_q   <= psel_decode(addr_d[SLOT_LSB +: SLOT_W]);
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
               cnt_q     <= '0;
`endif
            end
            ACCESS: begin
               if (PREADY) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  done_q    <= gnt_q;
                  rdata_q   <= pwrite_q ? '0 : PRDATA;
                  err_q     <= PSLVERR;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  ptr_q     <= ptr_d;
               end
`ifdef APB_ARB_TIMEOUT_EN
               // The final stalled ACCESS cycle ends the transfer with an error.
               else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  done_q    <= gnt_q;
                  rdata_q   <= '0;
                  err_q     <= 1'b1;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  ptr_q     <= ptr_d;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign DONE      = done_q;
   assign RSP_RDATA = rdata_q;
   assign RSP_ERR   = err_q;
   assign BUSY      = busy_q;
   assign PADDR     = paddr_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;

endmodule
